// File: rtl/voice_pkg.sv
// Shared constants, FSM state type and amplitude conversion for the voice scheduler.
package voice_pkg;

    localparam int NUM_VOICES_DEF = 4;
    localparam int MIX_W          = 10;
    localparam int PHASE_W        = 32;
    localparam int TONE_W         = 10;
    localparam int VOICE_W        = 2;
    localparam int LUT_W          = 6;
    localparam int AMP_W          = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Offset-binary table sample to a sign-extended mix-width value.
    function automatic logic signed [MIX_W-1:0] ampToSigned(input logic [AMP_W-1:0] amp);
        return {{(MIX_W-AMP_W){~amp[AMP_W-1]}}, ~amp[AMP_W-1], amp[AMP_W-2:0]};
    endfunction

endpackage

// File: rtl/voice_regfile.sv
// Per-voice tone/key-on/phase storage with a config write port that overrides
// the scheduler's phase-advance port when both hit the same voice.
module voice_regfile
    import voice_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEF
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               cfg_we_in,
    input  logic [VOICE_W-1:0] cfg_voice_in,
    input  logic [TONE_W-1:0]  cfg_tone_in,
    input  logic               cfg_on_in,
    input  logic               upd_en_in,
    input  logic [VOICE_W-1:0] upd_voice_in,
    input  logic [PHASE_W-1:0] upd_incr_in,
    input  logic [VOICE_W-1:0] rd_voice_in,
    output logic [TONE_W-1:0]  rd_tone_out,
    output logic               rd_on_out,
    output logic [LUT_W-1:0]   rd_lut_out
);

    logic [TONE_W-1:0]  tone_q  [NUM_VOICES];
    logic               on_q    [NUM_VOICES];
    logic [PHASE_W-1:0] phase_q [NUM_VOICES];
    logic [NUM_VOICES-1:0] cfgHit;
    logic [NUM_VOICES-1:0] updHit;

    always_comb begin
        cfgHit      = '0;
        updHit      = '0;
        rd_tone_out = '0;
        rd_on_out   = 1'b0;
        rd_lut_out  = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            cfgHit[v] = cfg_we_in && (cfg_voice_in == VOICE_W'(v));
            updHit[v] = upd_en_in && (upd_voice_in == VOICE_W'(v));
            if (rd_voice_in == VOICE_W'(v)) begin
                rd_tone_out = tone_q[v];
                rd_on_out   = on_q[v];
                rd_lut_out  = phase_q[v][PHASE_W-1 -: LUT_W];
            end
        end
    end

    // A key-off write clears the phase even if the voice is being advanced this edge.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                tone_q[v]  <= '0;
                on_q[v]    <= 1'b0;
                phase_q[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (cfgHit[v]) begin
                    tone_q[v] <= cfg_tone_in;
                    on_q[v]   <= cfg_on_in;
                end
                if (cfgHit[v] && !cfg_on_in) begin
                    phase_q[v] <= '0;
                end else if (updHit[v]) begin
                    phase_q[v] <= phase_q[v] + upd_incr_in;
                end
            end
        end
    end

endmodule

// File: rtl/voice_scheduler.sv
// Time-multiplexed voice mixer: each step issues every voice to the shared tone
// and sine tables, sums the returned amplitudes and publishes one mix sample.
module voice_scheduler
    import voice_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEF
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               step_in,
    input  logic               cfg_we_in,
    input  logic [VOICE_W-1:0] cfg_voice_in,
    input  logic [TONE_W-1:0]  cfg_tone_in,
    input  logic               cfg_on_in,
    output logic [TONE_W-1:0]  tone_out,
    input  logic [PHASE_W-1:0] phase_incr_in,
    output logic [LUT_W-1:0]   lut_phase_out,
    input  logic [AMP_W-1:0]   lut_amp_in,
    output logic [MIX_W-1:0]   mix_out,
    output logic               mix_valid_out,
    output logic               busy_out,
    output logic               overrun_out
);

    state_e                   state_q, state_d;
    logic [VOICE_W-1:0]       idx_q, idx_d;
    logic signed [MIX_W-1:0]  accum_q;
    logic                     pendOn_q;
    logic [MIX_W-1:0]         mixOut_q;
    logic                     mixValid_q;
    logic                     overrun_q;
    logic [TONE_W-1:0]        toneHold_q;
    logic [LUT_W-1:0]         lutHold_q;

    logic [TONE_W-1:0]        rdTone;
    logic                     rdOn;
    logic [LUT_W-1:0]         rdLut;
    logic                     running;
    logic                     issueOn;

    voice_regfile #(
        .NUM_VOICES (NUM_VOICES)
    ) u_regfile (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .cfg_we_in    (cfg_we_in),
        .cfg_voice_in (cfg_voice_in),
        .cfg_tone_in  (cfg_tone_in),
        .cfg_on_in    (cfg_on_in),
        .upd_en_in    (running && issueOn),
        .upd_voice_in (idx_q),
        .upd_incr_in  (phase_incr_in),
        .rd_voice_in  (idx_q),
        .rd_tone_out  (rdTone),
        .rd_on_out    (rdOn),
        .rd_lut_out   (rdLut)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (step_in) begin
                    state_d = RUN;
                    idx_d   = '0;
                end
            end
            RUN: begin
                if (idx_q == VOICE_W'(NUM_VOICES - 1)) begin
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A same-edge config write decides whether the voice being issued counts this frame.
    always_comb begin
        running       = (state_q == RUN);
        issueOn       = (cfg_we_in && (cfg_voice_in == idx_q)) ? cfg_on_in : rdOn;
        tone_out      = running ? rdTone : toneHold_q;
        lut_phase_out = running ? rdLut  : lutHold_q;
        busy_out      = (state_q != IDLE);
        mix_out       = mixOut_q;
        mix_valid_out = mixValid_q;
        overrun_out   = overrun_q;
    end

    // The sine table answers one cycle after issue, so the add trails issue by one cycle.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            accum_q    <= '0;
            pendOn_q   <= 1'b0;
            mixOut_q   <= '0;
            mixValid_q <= 1'b0;
            overrun_q  <= 1'b0;
            toneHold_q <= '0;
            lutHold_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pendOn_q   <= running && issueOn;
            mixValid_q <= (state_q == DONE);
            if (state_q == DONE) begin
                mixOut_q <= accum_q;
            end
            if ((state_q == IDLE) && step_in) begin
                accum_q <= '0;
            end else if (pendOn_q) begin
                accum_q <= accum_q + ampToSigned(lut_amp_in);
            end
            if (busy_out && step_in) begin
                overrun_q <= 1'b1;
            end
            if (running) begin
                toneHold_q <= rdTone;
                lutHold_q  <= rdLut;
            end
        end
    end

endmodule

// File: doc/voice_scheduler.md
VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 Parameter NUM_VOICES, default 4, number of time-multiplexed voices.
REQ-002 Port clk_in  input  1  system clock; all logic on rising edge.
REQ-003 Port rst_in  input  1  reset, synchronous and active-low.
REQ-004 Port step_in  input  1  one-cycle sample tick that starts one mix frame.
REQ-005 Port cfg_we_in  input  1  configuration write strobe.
REQ-006 Port cfg_voice_in  input  2  voice index for the configuration write.
REQ-007 Port cfg_tone_in  input  10  tone index for the configuration write.
REQ-008 Port cfg_on_in  input  1  key-on flag for the configuration write.
REQ-009 Port tone_out  output  10  tone index presented to the shared tone table.
REQ-010 Port phase_incr_in  input  32  combinational phase increment returned for tone_out.
REQ-011 Port lut_phase_out  output  6  phase index presented to the shared registered sine table.
REQ-012 Port lut_amp_in  input  8  offset-binary amplitude, valid one cycle after lut_phase_out.
REQ-013 Port mix_out  output  10  signed two's-complement sum of active voices.
REQ-014 Port mix_valid_out  output  1  one-cycle pulse when mix_out updates.
REQ-015 Port busy_out  output  1  high while a frame is in progress.
REQ-016 Port overrun_out  output  1  sticky flag set when step_in arrives while busy.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN, DONE. IDLE->RUN on step_in; RUN lasts NUM_VOICES cycles with index v=0..NUM_VOICES-1; RUN->DRAIN; DRAIN->DONE; DONE->IDLE.
REQ-018 In RUN with index v: tone_out=tone[v], lut_phase_out=phase[v][31:26], and phase[v]<=phase[v]+phase_incr_in (mod 2^32) if on[v].
REQ-019 In the cycle after voice v is issued (RUN index v+1 or DRAIN): accumulator += signed({~lut_amp_in[7],lut_amp_in[6:0]}) if on[v] at issue time, else += 0.
REQ-020 The accumulator clears on the IDLE->RUN transition; width 10 bits signed, no overflow possible for 4 voices.
REQ-021 In DONE: mix_out<=accumulator, mix_valid_out=1 for exactly that cycle. Latency: step_in sampled at edge N gives mix_valid_out high in cycle N+NUM_VOICES+2.
REQ-022 busy_out is high in RUN, DRAIN and DONE; low in IDLE.
REQ-023 step_in while busy_out=1 is ignored, no frame is queued, and overrun_out is set and held until reset.
REQ-024 In IDLE, tone_out and lut_phase_out hold their last values.
REQ-025 A cfg write applies on the same edge: tone[v]<=cfg_tone_in, on[v]<=cfg_on_in; cfg_on_in=0 also clears phase[v] to 0.
REQ-026 If a cfg write and the RUN phase update target the same voice on the same edge, the cfg write wins for tone, on and the phase clear. With cfg_on_in=1, the phase update proceeds using the old tone's increment.
REQ-027 A cfg write to a voice not yet issued in the current frame takes effect in that frame.
REQ-028 mix_out holds its value between DONE cycles.

Reset
REQ-029 While rst_in=0 at an edge: state=IDLE, all phase/tone/on cleared, accumulator=0, mix_out=0, mix_valid_out=0, overrun_out=0, tone_out=0, lut_phase_out=0.
REQ-030 Reset mid-frame aborts the frame with no mix_valid_out pulse; step_in during reset is ignored.

Structure
REQ-031 Package voice_pkg holds NUM_VOICES default, MIX_W=10, PHASE_W=32 and the FSM state enum.
REQ-032 A sub-module voice_regfile holds the per-voice tone/on/phase arrays, the cfg write port, and the update port with cfg priority.

Verification
REQ-033 Verification scenario 1: voice0 on, phase_incr=0x0400_0000, bench sine table, others off, three step_in pulses. Required mix_out sequence: 0, 12, 24 (table 128, 140, 152); valid 6 cycles after each step.
REQ-034 Verification scenario 2: all 4 voices on, same tone, first frame. Required mix_out=0; second frame mix_out=48.
REQ-035 Verification scenario 3: step_in pulsed again 2 cycles after the first. Required: one mix_valid_out pulse only, overrun_out=1 and remains 1.
REQ-036 Verification scenario 4: cfg_on_in=0 written to voice0 during RUN index 0. Required: phase[0]=0, voice0 contributes 0 in that frame.
REQ-037 Verification scenario 5: rst_in low in the DRAIN cycle. Required: no valid pulse, mix_out=0, busy_out=0 on the next cycle.
REQ-038 Verification scenario 6: lut_amp_in=0 for all voices, 4 voices on. Required: mix_out=-512 (10'h200).
